// File: rtl/dm_dump_reader.sv
// dm_dump_reader: walks the data memory over the MEM stage debug port while
// the pipeline is halted and streams every word, least significant byte
// first, to the debug UART transmitter over a valid/ready handshake.
module dm_dump_reader #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 7,
  parameter int N_WORDS    = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_dm_addr,
  output logic               o_dm_enable_addr,
  output logic               o_dm_enable,
  output logic               o_dm_enable_read,
  output logic               o_enable_mem,
  input  logic [NB_DATA-1:0] i_dm_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_LAT  = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam int NB_WCNT = (N_WORDS < 2) ? 1 : $clog2(N_WORDS);

  localparam logic [NB_LAT-1:0]  LAT_MAX   = NB_LAT'(RD_LATENCY);
  localparam logic [NB_WCNT-1:0] LAST_WORD = NB_WCNT'(N_WORDS - 1);
  localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(4);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [NB_ADDR-1:0]  addr_reg;
  logic [NB_WCNT-1:0]  word_cnt;
  logic [1:0]          byte_idx;
  logic [NB_LAT-1:0]   lat_cnt;
  logic [NB_DATA-1:0]  word_reg;

  logic                dbg_en;
  logic                tx_valid;
  logic                done_pulse;
  logic                last_byte;
  logic                last_word;

  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (word_cnt == LAST_WORD);

  // State register; reset drops any dump in progress straight back to IDLE.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; debug enables cover the whole ADDR..SEND span.
  always_comb begin
    state_next = state;
    dbg_en     = 1'b0;
    tx_valid   = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        dbg_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        dbg_en = 1'b1;
        if (lat_cnt == LAT_MAX) begin
          state_next = SEND;
        end
      end
      SEND: begin
        dbg_en   = 1'b1;
        tx_valid = 1'b1;
        if (i_tx_ready && last_byte) begin
          state_next = last_word ? DONE : ADDR;
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address, counters and captured word; the address only advances after the
  // last byte of a word so it stays stable through the whole read latency.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_reg <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      lat_cnt  <= '0;
      word_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            addr_reg <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            lat_cnt  <= '0;
          end
        end
        ADDR: begin
          lat_cnt <= NB_LAT'(1);
        end
        WAIT: begin
          if (lat_cnt == LAT_MAX) begin
            word_reg <= i_dm_data;
          end else begin
            lat_cnt <= lat_cnt + NB_LAT'(1);
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            byte_idx <= byte_idx + 2'd1;
            if (last_byte && !last_word) begin
              addr_reg <= addr_reg + WORD_STEP;
              word_cnt <= word_cnt + NB_WCNT'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_dm_addr        = dbg_en ? addr_reg : '0;
  assign o_dm_enable_addr = dbg_en;
  assign o_dm_enable      = dbg_en;
  assign o_dm_enable_read = dbg_en;
  assign o_enable_mem     = dbg_en;
  assign o_tx_valid       = tx_valid;
  assign o_tx_data        = tx_valid ? word_reg[{byte_idx, 3'b000} +: 8] : 8'h00;
  assign o_busy           = (state != IDLE);
  assign o_done           = done_pulse;

endmodule
